// File: rtl/uart_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uart_arb_pkg
// Brief   : Shared FSM encoding, pointer width and defaults for the UART
//           port arbiter.
// Rev     : 1.0
// ============================================================================
package uart_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_ACK   = 2'd3
    } arb_state_t;

    localparam int          c_ptr_w          = 2;
    localparam logic [31:0] c_nodata_default = 32'hFFFF_FFFF;

    // Advance a round-robin index, wrapping after the highest requester.
    function automatic logic [c_ptr_w-1:0] rr_next(
        input logic [c_ptr_w-1:0] cur,
        input logic [c_ptr_w-1:0] last
    );
        return (cur == last) ? '0 : cur + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module  : rr_pick
// Brief   : Picks the first asserted request at or after ptr, wrapping.
// Rev     : 1.0
// ============================================================================
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]    req,
    input  logic [c_ptr_w-1:0] ptr,
    output logic [c_ptr_w-1:0] grant,
    output logic               any
);

    localparam int c_idx_w = c_ptr_w + 1;

    logic [c_idx_w-1:0] w_idx;

    always_comb begin
        grant = '0;
        w_idx = '0;
        // Scan farthest-first so the nearest requester is the last to write grant.
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_idx = {1'b0, ptr} + c_idx_w'(k);
            if (w_idx >= c_idx_w'(NREQ)) begin
                w_idx = w_idx - c_idx_w'(NREQ);
            end
            if (req[w_idx[c_ptr_w-1:0]]) begin
                grant = w_idx[c_ptr_w-1:0];
            end
        end
    end

    assign any = |req;

endmodule
`default_nettype wire

// File: rtl/uart_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : uart_port_arbiter
// Brief   : Shares one UART data register between NREQ transmit requesters
//           (round-robin) and a single-entry receive buffer.
// Rev     : 1.0
// ============================================================================
module uart_port_arbiter
    import uart_arb_pkg::*;
#(
    parameter int          NREQ   = 4,
    parameter logic [31:0] NODATA = c_nodata_default
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      tx_req,
    input  logic [8*NREQ-1:0]    tx_data,
    output logic [NREQ-1:0]      tx_ack,
    output logic                 rx_valid,
    output logic [7:0]           rx_data,
    input  logic                 rx_ready,
    output logic                 reg_dat_we,
    output logic                 reg_dat_re,
    output logic [31:0]          reg_dat_di,
    input  logic [31:0]          reg_dat_do,
    input  logic                 reg_dat_wait,
    output logic [c_ptr_w-1:0]   grant_id,
    output logic                 busy
);

    localparam logic [c_ptr_w-1:0] c_last = c_ptr_w'(NREQ - 1);

    arb_state_t         r_state;
    arb_state_t         w_state_nxt;
    logic [c_ptr_w-1:0] r_grant;
    logic [c_ptr_w-1:0] r_rr_ptr;
    logic               r_poll_turn;
    logic               r_rx_valid;
    logic [7:0]         r_rx_data;
    logic [7:0]         r_di;
    logic [c_ptr_w-1:0] w_pick;
    logic               w_any;
    logic [7:0]         w_sel_byte;

    rr_pick #(
        .NREQ (NREQ)
    ) u_rr_pick (
        .req   (tx_req),
        .ptr   (r_rr_ptr),
        .grant (w_pick),
        .any   (w_any)
    );

    always_comb begin
        w_sel_byte = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_pick == c_ptr_w'(i)) begin
                w_sel_byte = tx_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Strobes depend only on the state register, never on live inputs.
    always_comb begin
        w_state_nxt = r_state;
        reg_dat_re  = 1'b0;
        reg_dat_we  = 1'b0;
        tx_ack      = '0;
        unique case (r_state)
            ST_IDLE: begin
                if (!r_rx_valid && (r_poll_turn || !w_any)) begin
                    w_state_nxt = ST_READ;
                end else if (w_any) begin
                    w_state_nxt = ST_WRITE;
                end
            end
            ST_READ: begin
                reg_dat_re  = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            ST_WRITE: begin
                reg_dat_we = 1'b1;
                if (!reg_dat_wait) begin
                    w_state_nxt = ST_ACK;
                end
            end
            ST_ACK: begin
                for (int i = 0; i < NREQ; i++) begin
                    tx_ack[i] = (r_grant == c_ptr_w'(i));
                end
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_grant     <= '0;
            r_rr_ptr    <= '0;
            r_poll_turn <= 1'b1;
            r_rx_valid  <= 1'b0;
            r_rx_data   <= '0;
            r_di        <= '0;
        end else begin
            if (r_rx_valid && rx_ready) begin
                r_rx_valid <= 1'b0;
            end
            unique case (r_state)
                ST_IDLE: begin
                    if (w_state_nxt == ST_WRITE) begin
                        r_grant <= w_pick;
                        r_di    <= w_sel_byte;
                    end
                end
                ST_READ: begin
                    r_poll_turn <= 1'b0;
                    if (reg_dat_do != NODATA) begin
                        r_rx_data  <= reg_dat_do[7:0];
                        r_rx_valid <= 1'b1;
                    end
                end
                ST_ACK: begin
                    r_rr_ptr    <= rr_next(r_grant, c_last);
                    r_poll_turn <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign rx_valid   = r_rx_valid;
    assign rx_data    = r_rx_data;
    assign reg_dat_di = {24'b0, r_di};
    assign grant_id   = r_grant;
    assign busy       = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_port_arbiter
// Brief   : Scoreboard bench for uart_port_arbiter with a transaction model.
// Rev     : 1.0
// ============================================================================
module tb_uart_port_arbiter;

    localparam int          NREQ     = 4;
    localparam logic [31:0] c_nodata = 32'hFFFF_FFFF;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NREQ-1:0]   tx_req = '0;
    logic [8*NREQ-1:0] tx_data = '0;
    logic [NREQ-1:0]   tx_ack;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready = 1'b0;
    logic              reg_dat_we, reg_dat_re;
    logic [31:0]       reg_dat_di;
    logic [31:0]       reg_dat_do = c_nodata;
    logic              reg_dat_wait = 1'b0;
    logic [1:0]        grant_id;
    logic              busy;

    uart_port_arbiter #(.NREQ(NREQ), .NODATA(c_nodata)) dut (
        .clk(clk), .reset(reset), .tx_req(tx_req), .tx_data(tx_data),
        .tx_ack(tx_ack), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rx_ready), .reg_dat_we(reg_dat_we), .reg_dat_re(reg_dat_re),
        .reg_dat_di(reg_dat_di), .reg_dat_do(reg_dat_do),
        .reg_dat_wait(reg_dat_wait), .grant_id(grant_id), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_total++;
        $display("FAIL %s: got nothing, expected an event", name);
    endtask

    // Stimulus state and knobs
    logic       pending [NREQ];
    logic       dropped [NREQ];
    logic [7:0] data_b  [NREQ];
    logic [7:0] exp_tx  [NREQ][$];
    logic [7:0] exp_rx  [$];
    int rx_pct, wait_pct, ready_pct, drop_pct, issue_pct, wait_hold;
    bit force_ff;
    logic [NREQ-1:0] drop_mask, reissue;

    // Reference model state
    int         m_ptr = 0;
    bit         m_poll = 1;
    bit         m_rx_full = 0;
    bit         ack_due = 0;
    logic [1:0] m_grant = '0;
    int         exp_code = -1;
    logic [NREQ-1:0] idle_req = '0;
    bit         prev_we = 0;
    logic [31:0] di_entry = '0, last_commit_di = '0;
    int cyc = 0, we_len = 0, last_we_len = 0, decide_cyc = 0, last_ack_cyc = 0, n_reads = 0;
    int ack_cnt [NREQ];
    int ev_log [$];

    function automatic logic [1:0] rr_first(input logic [NREQ-1:0] req, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (ptr + k) % NREQ;
            if (req[idx]) return 2'(idx);
        end
        return 2'd0;
    endfunction

    task automatic apply_req();
        for (int i = 0; i < NREQ; i++) begin
            tx_req[i] = pending[i] && !dropped[i];
            tx_data[8*i +: 8] = data_b[i];
        end
    endtask

    task automatic issue(input int i, input logic [7:0] b);
        pending[i] = 1'b1;
        dropped[i] = 1'b0;
        data_b[i]  = b;
        exp_tx[i].push_back(b);
        apply_req();
    endtask

    task automatic quiet();
        rx_pct = 0; wait_pct = 0; ready_pct = 100; drop_pct = 0; issue_pct = 0;
        force_ff = 0; drop_mask = '0;
    endtask

    task automatic drive_cycle();
        logic [7:0] b;
        @(negedge clk);
        if (reg_dat_re) begin
            if ($urandom_range(99) < rx_pct) begin
                b = force_ff ? 8'hFF : 8'($urandom);
                reg_dat_do = {24'h0, b};
                exp_rx.push_back(b);
            end else begin
                reg_dat_do = c_nodata;
            end
        end else begin
            reg_dat_do = $urandom;
        end
        if (reg_dat_we && wait_hold > 0) begin
            reg_dat_wait = 1'b1;
            wait_hold--;
        end else if (reg_dat_we) begin
            reg_dat_wait = ($urandom_range(99) < wait_pct);
        end else begin
            reg_dat_wait = 1'($urandom_range(1));
        end
        rx_ready = ($urandom_range(99) < ready_pct);
        for (int i = 0; i < NREQ; i++) begin
            if (tx_ack[i]) begin
                pending[i] = 1'b0;
                dropped[i] = 1'b0;
                if (reissue[i]) begin
                    reissue[i] = 1'b0;
                    issue(i, data_b[i]);
                end else if (issue_pct > 0 && $urandom_range(99) < issue_pct) begin
                    issue(i, 8'($urandom));
                end
            end else if (!pending[i]) begin
                if (issue_pct > 0 && $urandom_range(99) < issue_pct) issue(i, 8'($urandom));
            end else if (reg_dat_we && grant_id == 2'(i) && !dropped[i] &&
                         (drop_mask[i] || $urandom_range(99) < drop_pct)) begin
                dropped[i]   = 1'b1;
                drop_mask[i] = 1'b0;
            end
        end
        apply_req();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            pending[i] = 1'b0;
            dropped[i] = 1'b0;
            exp_tx[i].delete();
        end
        exp_rx.delete();
        wait_hold = 0; reissue = '0; drop_mask = '0;
        apply_req();
        #1;
        check("rst_we", reg_dat_we, 0);
        check("rst_re", reg_dat_re, 0);
        check("rst_di", reg_dat_di, 0);
        check("rst_ack", tx_ack, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_grant", grant_id, 0);
        check("rst_busy", busy, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic bit sb_idle();
        if (exp_rx.size() != 0 || rx_valid || ack_due) return 0;
        for (int i = 0; i < NREQ; i++)
            if (pending[i] || exp_tx[i].size() != 0) return 0;
        return 1;
    endfunction

    task automatic drain();
        quiet();
        for (int n = 0; n < 400; n++) begin
            drive_cycle();
            if (sb_idle()) return;
        end
        fail_now("drain_timeout");
    endtask

    task automatic run_until_we(input int max);
        for (int n = 0; n < max; n++) begin
            drive_cycle();
            if (reg_dat_we) return;
        end
        fail_now("write_timeout");
    endtask

    // Monitor: compares DUT activity with the transaction-level model.
    always begin
        int act;
        bit rx_set;
        logic [7:0] b;
        @(negedge clk);
        #1;
        if (reset) begin
            m_ptr = 0; m_poll = 1; m_rx_full = 0; ack_due = 0; exp_code = -1;
            prev_we = 0; ev_log.delete();
        end else begin
            cyc++;
            rx_set = 0;
            act = reg_dat_re ? 1 : reg_dat_we ? 2 : busy ? 3 : 0;
            if (exp_code >= 0) check("next_action", act, exp_code);
            exp_code = -1;
            check("rx_valid", rx_valid, m_rx_full);
            check("tx_ack", tx_ack, ack_due ? (32'd1 << m_grant) : 32'd0);
            for (int i = 0; i < NREQ; i++) if (tx_ack[i]) ack_cnt[i]++;
            if (ack_due) begin
                m_ptr = (int'(m_grant) + 1) % NREQ;
                m_poll = 1;
                last_ack_cyc = cyc;
                ack_due = 0;
            end
            if (!busy) begin
                if (!m_rx_full && (m_poll || tx_req == '0)) exp_code = 1;
                else if (tx_req != '0) begin
                    exp_code = 2;
                    decide_cyc = cyc;
                end else exp_code = 0;
                idle_req = tx_req;
            end
            if (reg_dat_re) begin
                ev_log.push_back(9);
                n_reads++;
                m_poll = 0;
                if (reg_dat_do != c_nodata) rx_set = 1;
            end
            if (reg_dat_we) begin
                if (!prev_we) begin
                    m_grant = rr_first(idle_req, m_ptr);
                    check("grant", grant_id, m_grant);
                    di_entry = reg_dat_di;
                    we_len = 0;
                end else begin
                    check("di_stable", reg_dat_di, di_entry);
                end
                we_len++;
                if (!reg_dat_wait) begin
                    if (exp_tx[m_grant].size() == 0) fail_now("tx_scoreboard_empty");
                    else begin
                        b = exp_tx[m_grant].pop_front();
                        check("tx_di", reg_dat_di, {24'h0, b});
                    end
                    last_commit_di = reg_dat_di;
                    last_we_len = we_len;
                    ack_due = 1;
                    ev_log.push_back(int'(m_grant));
                end
            end
            prev_we = reg_dat_we;
            if (m_rx_full && rx_ready) begin
                if (exp_rx.size() == 0) fail_now("rx_scoreboard_empty");
                else check("rx_data", rx_data, exp_rx.pop_front());
                m_rx_full = 0;
            end
            if (rx_set) m_rx_full = 1;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got time limit, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seq [10] = '{9, 0, 9, 1, 9, 2, 9, 3, 9, 0};
        int r0, a0;
        for (int i = 0; i < NREQ; i++) begin
            pending[i] = 0; dropped[i] = 0; data_b[i] = '0; ack_cnt[i] = 0;
        end
        wait_hold = 0; reissue = '0;
        quiet();

        // Single requester: one poll, then write 0x41, ack two cycles after decision
        do_reset();
        issue(0, 8'h41);
        drain();
        check("d1_first_read", (ev_log.size() > 1) ? ev_log[0] : -1, 9);
        check("d1_then_write0", (ev_log.size() > 1) ? ev_log[1] : -1, 0);
        check("d1_di", last_commit_di, 32'h41);
        check("d1_ack_latency", last_ack_cyc - decide_cyc, 2);

        // All four requesting: 30,31,32,33,30 with a poll between each write
        do_reset();
        reissue = 4'b0001;
        for (int i = 0; i < NREQ; i++) issue(i, 8'h30 + 8'(i));
        drain();
        for (int k = 0; k < 10; k++)
            check("d2_sequence", (ev_log.size() > k) ? ev_log[k] : -1, seq[k]);
        check("d2_last_di", last_commit_di, 32'h30);

        // Write stall held for 10 cycles
        wait_hold = 10;
        issue(1, 8'h5A);
        drain();
        check("d3_we_len", last_we_len, 11);
        check("d3_di", last_commit_di, 32'h5A);

        // 0xFF is real data; no further polling until consumed
        quiet();
        rx_pct = 100; force_ff = 1; ready_pct = 0;
        r0 = n_reads;
        repeat (20) drive_cycle();
        check("d4_rx_valid", rx_valid, 1);
        check("d4_rx_data", rx_data, 8'hFF);
        check("d4_single_read", n_reads - r0, 1);
        rx_pct = 0; ready_pct = 100;
        drive_cycle();
        drain();

        // Reset during a stalled write, then requester 0 served first
        issue(0, 8'h11);
        drain();
        wait_hold = 50;
        issue(1, 8'h22);
        run_until_we(20);
        a0 = ack_cnt[1];
        do_reset();
        issue(1, 8'h33);
        issue(0, 8'h44);
        run_until_we(20);
        check("d5_first_grant", grant_id, 0);
        drain();
        check("d5_no_stale_ack", ack_cnt[1] - a0, 1);

        // Requester 2 drops its request mid-write
        a0 = ack_cnt[2];
        wait_hold = 3;
        drop_mask = 4'b0100;
        issue(2, 8'h77);
        drop_mask = 4'b0100;
        run_until_we(20);
        drain();
        check("d6_ack_once", ack_cnt[2] - a0, 1);
        check("d6_di", last_commit_di, 32'h77);

        // Randomized traffic against the model
        rx_pct = 40; wait_pct = 30; ready_pct = 50; drop_pct = 10; issue_pct = 15;
        repeat (3000) drive_cycle();
        drain();
        check("final_idle", sb_idle(), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
